serial_tx_framer: RTL



---
 rtl/serial_link_pkg.sv | 22 ++
 rtl/serial_tx_framer_bit_period_timer.sv | 31 +++
 rtl/serial_tx_framer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and line constants for the serial link transmit/capture path.
// Optional parity support is controlled by SERIAL_TX_PARITY_EN in the framer.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_framer_bit_period_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A clear pulse restarts the period so the first bit of a frame is full length.
module bit_period_timer
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = idx_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-in serial-out framer: start bit, DATA_W bits LSB-first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_framer
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [IDX_W-1:0]  bit_idx;
  logic              accept;
  logic              tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_bit;
`endif

  // tx_ready is only high in IDLE, so this is the accept edge.
  assign accept = tx_valid && tx_ready;

  always_comb begin
    shift_next = shift >> 1;
  end

  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      tx_out     <= LINE_IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift      <= tx_data;
            bit_idx    <= '0;
            state      <= START;
            tx_out     <= START_BIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            tx_out <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_bit;
`else
              state  <= STOP;
              tx_out <= STOP_BIT;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift_next;
              tx_out  <= shift_next[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            tx_out <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            state    <= IDLE;
            tx_out   <= LINE_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_out   <= LINE_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
